// File: rtl/if_stage.sv
// Instruction-fetch stage: PC sequencing, busywait handshake, stall skid buffer
// and redirect handling feeding the IF/ID pipeline register.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        i_mem_read,
  output logic [31:0] i_mem_addr,
  input  logic        i_mem_busywait,
  input  logic [31:0] i_mem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [6:0]  opcode,
  output logic [2:0]  fun_3,
  output logic [6:0]  fun_7
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] pc, pc_next;
  logic [XLEN-1:0] pending, pending_next;
  logic [XLEN-1:0] skid, skid_next;
  logic [XLEN-1:0] instr_q, instr_next;
  logic [XLEN-1:0] pc_q, pc_q_next;
  logic [XLEN-1:0] pc4_q, pc4_q_next;
  logic            valid_q, valid_next;

  logic            req_active;
  logic            complete;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_plus4;

  assign req_active = (state != HOLD);
  assign complete   = req_active && !i_mem_busywait;
  assign target     = {redirect_pc[XLEN-1:2], 2'b00};
  assign pc_plus4   = pc + PC_STEP;

  // Next-state and datapath updates; redirect dominates stall in every state
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    pending_next = pending;
    skid_next    = skid;
    instr_next   = instr_q;
    pc_q_next    = pc_q;
    pc4_q_next   = pc4_q;
    valid_next   = valid_q;

    unique case (state)
      FETCH: begin
        if (redirect) begin
          valid_next = 1'b0;
          instr_next = NOP_INSTR;
          if (complete) begin
            pc_next = target;
          end else begin
            pending_next = target;
            state_next   = DISCARD;
          end
        end else if (complete) begin
          if (stall) begin
            skid_next  = i_mem_rdata;
            state_next = HOLD;
          end else begin
            instr_next = i_mem_rdata;
            pc_q_next  = pc;
            pc4_q_next = pc_plus4;
            valid_next = 1'b1;
            pc_next    = pc_plus4;
          end
        end else if (!stall) begin
          valid_next = 1'b0;
          instr_next = NOP_INSTR;
        end
      end

      HOLD: begin
        if (redirect) begin
          valid_next = 1'b0;
          instr_next = NOP_INSTR;
          pc_next    = target;
          state_next = FETCH;
        end else if (!stall) begin
          instr_next = skid;
          pc_q_next  = pc;
          pc4_q_next = pc_plus4;
          valid_next = 1'b1;
          pc_next    = pc_plus4;
          state_next = FETCH;
        end
      end

      DISCARD: begin
        if (redirect) begin
          valid_next   = 1'b0;
          instr_next   = NOP_INSTR;
          pending_next = target;
          if (complete) begin
            pc_next    = target;
            state_next = FETCH;
          end
        end else begin
          if (!stall) begin
            valid_next = 1'b0;
            instr_next = NOP_INSTR;
          end
          if (complete) begin
            pc_next    = pending;
            state_next = FETCH;
          end
        end
      end

      default: begin
        state_next = FETCH;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      pending <= '0;
      skid    <= '0;
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      pc4_q   <= PC_STEP;
      valid_q <= 1'b0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      pending <= pending_next;
      skid    <= skid_next;
      instr_q <= instr_next;
      pc_q    <= pc_q_next;
      pc4_q   <= pc4_q_next;
      valid_q <= valid_next;
    end
  end

  // Request is suppressed during reset so no fetch leaks out before RESET_PC
  assign i_mem_read  = req_active && !RESET;
  assign i_mem_addr  = pc;
  assign if_id_instr = instr_q;
  assign if_id_pc    = pc_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;
  assign opcode      = instr_q[6:0];
  assign fun_3       = instr_q[14:12];
  assign fun_7       = instr_q[31:25];

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage with an address-derived memory model.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        i_mem_read;
  logic [31:0] i_mem_addr;
  logic        i_mem_busywait;
  logic [31:0] i_mem_rdata;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [6:0]  opcode;
  logic [2:0]  fun_3;
  logic [6:0]  fun_7;

  int passed = 0;
  int total  = 0;

  if_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .i_mem_read     (i_mem_read),
    .i_mem_addr     (i_mem_addr),
    .i_mem_busywait (i_mem_busywait),
    .i_mem_rdata    (i_mem_rdata),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc4      (if_id_pc4),
    .if_id_valid    (if_id_valid),
    .opcode         (opcode),
    .fun_3          (fun_3),
    .fun_7          (fun_7)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[8:0], 7'h33};
  endfunction

  assign i_mem_rdata = mem_word(i_mem_addr);

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) begin
      passed = passed + 1;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic valid);
    chk({tag, "_valid"}, 32'(if_id_valid), 32'(valid));
    if (valid) begin
      chk({tag, "_pc"}, if_id_pc, pc);
      chk({tag, "_pc4"}, if_id_pc4, pc + 32'd4);
      chk({tag, "_instr"}, if_id_instr, mem_word(pc));
    end else begin
      chk({tag, "_instr"}, if_id_instr, NOP);
      chk({tag, "_opcode"}, 32'(opcode), 32'h13);
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  logic [31:0] w;

  initial begin
    RESET = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; i_mem_busywait = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(if_id_valid), 32'd0);
    chk("rst_instr", if_id_instr, NOP);
    chk("rst_pc", if_id_pc, 32'd0);
    chk("rst_pc4", if_id_pc4, 32'd4);
    chk("rst_read", 32'(i_mem_read), 32'd0);
    chk("rst_addr", i_mem_addr, 32'd0);
    RESET = 1'b0;
    #1;
    chk("post_rst_read", 32'(i_mem_read), 32'd1);

    // Zero-wait streaming
    tick(); chk_ifid("s1_0", 32'h0, 1'b1);
    w = mem_word(32'h0);
    chk("s1_fun3", 32'(fun_3), 32'(w[14:12]));
    chk("s1_fun7", 32'(fun_7), 32'(w[31:25]));
    tick(); chk_ifid("s1_4", 32'h4, 1'b1);
    tick(); chk_ifid("s1_8", 32'h8, 1'b1);
    tick(); chk_ifid("s1_c", 32'hC, 1'b1);

    // Busywait on 0x4 produces bubbles
    do_reset();
    tick(); chk_ifid("s2_0", 32'h0, 1'b1);
    i_mem_busywait = 1'b1;
    tick(); chk_ifid("s2_b1", 32'h0, 1'b0); chk("s2_addr1", i_mem_addr, 32'h4);
    tick(); chk_ifid("s2_b2", 32'h0, 1'b0); chk("s2_addr2", i_mem_addr, 32'h4);
    i_mem_busywait = 1'b0;
    tick(); chk_ifid("s2_4", 32'h4, 1'b1);

    // Stall during completion of 0x8 goes to HOLD
    stall = 1'b1;
    tick();
    chk("s3_read", 32'(i_mem_read), 32'd0);
    chk("s3_addr", i_mem_addr, 32'h8);
    chk_ifid("s3_hold", 32'h4, 1'b1);
    tick();
    chk_ifid("s3_hold2", 32'h4, 1'b1);
    stall = 1'b0;
    tick(); chk_ifid("s3_8", 32'h8, 1'b1); chk("s3_addr_c", i_mem_addr, 32'hC);
    tick(); chk_ifid("s3_c", 32'hC, 1'b1);

    // Redirect to 0x103 while 0x10 busy
    chk("s4_addr_pre", i_mem_addr, 32'h10);
    i_mem_busywait = 1'b1; redirect = 1'b1; redirect_pc = 32'h103;
    tick();
    chk_ifid("s4_r", 32'h0, 1'b0);
    chk("s4_read", 32'(i_mem_read), 32'd1);
    chk("s4_addr1", i_mem_addr, 32'h10);
    redirect = 1'b0;
    tick(); chk("s4_addr2", i_mem_addr, 32'h10); chk_ifid("s4_w", 32'h0, 1'b0);
    i_mem_busywait = 1'b0;
    tick(); chk_ifid("s4_drop", 32'h0, 1'b0); chk("s4_addr3", i_mem_addr, 32'h100);
    tick(); chk_ifid("s4_100", 32'h100, 1'b1);

    // Redirect and stall together while in HOLD
    stall = 1'b1;
    tick(); chk("s5_read", 32'(i_mem_read), 32'd0); chk_ifid("s5_hold", 32'h100, 1'b1);
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    chk_ifid("s5_r", 32'h0, 1'b0);
    chk("s5_addr", i_mem_addr, 32'h200);
    chk("s5_fetch", 32'(i_mem_read), 32'd1);
    redirect = 1'b0; stall = 1'b0;
    tick(); chk_ifid("s5_200", 32'h200, 1'b1);

    // Last redirect wins in DISCARD
    i_mem_busywait = 1'b1; redirect = 1'b1; redirect_pc = 32'h300;
    tick();
    redirect_pc = 32'h400;
    tick();
    redirect = 1'b0; i_mem_busywait = 1'b0;
    tick(); chk("s6_addr", i_mem_addr, 32'h400); chk_ifid("s6_bub", 32'h0, 1'b0);
    tick(); chk_ifid("s6_400", 32'h400, 1'b1);

    // Unaligned target is forced aligned; PC+4 wraps
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    tick(); chk("s7_addr", i_mem_addr, 32'hFFFF_FFFC);
    redirect = 1'b0;
    tick();
    chk("s7_pc", if_id_pc, 32'hFFFF_FFFC);
    chk("s7_pc4", if_id_pc4, 32'h0);
    chk("s7_wrap", i_mem_addr, 32'h0);

    // Reset mid-wait at PC=0x40
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect = 1'b0; i_mem_busywait = 1'b1;
    tick(); chk("s8_addr", i_mem_addr, 32'h40);
    RESET = 1'b1;
    #1 chk("s8_read_comb", 32'(i_mem_read), 32'd0);
    tick();
    chk("s8_read", 32'(i_mem_read), 32'd0);
    chk("s8_valid", 32'(if_id_valid), 32'd0);
    RESET = 1'b0; i_mem_busywait = 1'b0;
    #1;
    chk("s8_addr_rst", i_mem_addr, 32'h0);
    chk("s8_read_rel", 32'(i_mem_read), 32'd1);
    tick(); chk_ifid("s8_0", 32'h0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
